tex_wrap_pipe: RTL and testbench
================================

Name: tex_wrap_pipe

Overview:
- Multi-lane, two-dimensional texture-coordinate wrap unit, pipelined with a valid/ready handshake.
- Sits between the texture address-generation stage and the texel-address/filter stage.
- Maps fixed-point (u,v) coordinates per lane to normalized fractional coordinates. Supports CLAMP, REPEAT and MIRROR, and adds a BORDER mode that flags out-of-range texels.
- Independent wrap mode per dimension; tag and lane mask carried alongside the data.

Parameters:
- NUM_LANES, 4, lanes processed per request.
- FXD_BITS, 32, width of the signed two's-complement input coordinate.
- FRAC_BITS, 20, fractional bits. 1.0 = 2^FRAC_BITS. Output width. Must be < FXD_BITS.
- TAG_WIDTH, 8, opaque request tag width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_wrap_u  in  2  wrap mode for u: 0 CLAMP, 1 REPEAT, 2 MIRROR, 3 BORDER.
- req_wrap_v  in  2  wrap mode for v, same encoding.
- req_mask  in  NUM_LANES  active lanes.
- req_coords  in  NUM_LANES*2*FXD_BITS  per lane {v,u}; lane 0 in LSBs.
- req_tag  in  TAG_WIDTH  request tag.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  downstream accepts.
- rsp_coords  out  NUM_LANES*2*FRAC_BITS  per lane {v,u} wrapped fractions.
- rsp_border  out  NUM_LANES  lane sampled outside [0,1) under a BORDER dimension.
- rsp_mask  out  NUM_LANES  registered req_mask.
- rsp_tag  out  TAG_WIDTH  registered req_tag.
- border_count  out  32  running count of accepted lanes with border=1.

Behaviour:
- Reset is synchronous and active-high. Clock is clk, reset is reset.
- Reset values: rsp_valid=0, rsp_coords=0, rsp_border=0, rsp_mask=0, rsp_tag=0, border_count=0; both pipeline stage valids cleared.
- Reset mid-operation discards all in-flight requests. No response is produced for them.
- Pipeline: two elastic register stages.
  - S1 registers the inputs plus the computed in-range flags.
  - S2 registers the wrapped result.
  - Latency: 2 cycles from accept to rsp_valid when unstalled. Throughput: 1 request/cycle.
- Stage advance rule: a stage loads when it is empty or its contents are being consumed this cycle.
  - req_ready = !s1_valid || (!s2_valid || rsp_ready). req_ready is combinational from state and rsp_ready.
  - Back-to-back transfers with rsp_ready held at 1 never bubble.
  - With rsp_ready=0, up to 2 requests are held. req_ready drops only when both stages are full.
  - Held outputs must remain stable while rsp_valid && !rsp_ready.
- Per-coordinate arithmetic (c = FXD_BITS signed, f = c[FRAC_BITS-1:0], p = c[FRAC_BITS]):
  - REPEAT: out = f.
  - MIRROR: out = f XOR {FRAC_BITS{p}}.
  - CLAMP: c<0 gives 0; c>=2^FRAC_BITS gives all-ones (2^FRAC_BITS-1); else f.
  - BORDER: if 0<=c<2^FRAC_BITS then out = f; else out = 0 and the out-of-range flag is set for that dimension.
- rsp_border[i] = mask[i] && (u out-of-range under BORDER || v out-of-range under BORDER). A non-BORDER dimension never contributes.
- Masked-off lanes: rsp_coords lane = 0, rsp_border bit = 0.
- border_count:
  - Increments by popcount(rsp_border) on each rsp handshake (rsp_valid && rsp_ready).
  - Wraps modulo 2^32.
  - Increments by nothing while stalled.
- Wrap mode, mask and tag are captured with the request and apply to that request only. Modes may change every cycle.

Test Plan:
- Reset check: assert reset during traffic with rsp_ready=0 -> next cycle rsp_valid=0, all outputs 0, border_count=0, req_ready=1.
- Positive out-of-range value: u=0x00180000 (1.5), all four modes in turn -> REPEAT 0x80000, MIRROR 0x7FFFF, CLAMP 0xFFFFF, BORDER 0x00000 with rsp_border=1. rsp_valid appears exactly 2 cycles after accept.
- Negative value: u=0xFFFC0000 (-0.25) -> REPEAT 0xC0000, MIRROR 0x3FFFF, CLAMP 0x00000, BORDER 0 with rsp_border=1.
- In-range value: u=0x00040000 under BORDER -> 0x40000, border=0.
- Mixed modes per dimension: u BORDER out-of-range, v REPEAT 2.25 (0x00240000) -> u=0, v=0x40000, border=1.
- Mask: mask=4'b0101, all lanes out-of-range under BORDER -> rsp_border=4'b0101, lanes 1 and 3 coords=0, border_count +=2.
- Backpressure: stream 6 requests with tags 0..5 while rsp_ready toggles 1,0,0,1,... ->
  - tags emerge in order with no loss or duplication;
  - req_ready=0 only when both stages are full;
  - outputs stay stable during stalls;
  - border_count matches the reference-model popcount sum.
- Throughput: continuous req_valid=1 with rsp_ready=1 for 16 cycles -> 16 responses on consecutive cycles after the 2-cycle fill.

Source files
------------

// File: rtl/tex_wrap_pipe.sv
// tex_wrap_pipe: multi-lane 2D texture-coordinate wrap unit.
// Two elastic register stages: S1 holds decoded range flags, S2 holds the
// wrapped fractions. Lane 0 sits in the LSBs and each lane is packed {v,u}.

// Per-lane wrap datapath for both dimensions (index 0 = u, 1 = v).
// The decode half feeds the S1 register and the wrap half reads it back.
module tex_wrap_lane #(
  parameter int FXD_BITS  = 32,
  parameter int FRAC_BITS = 20
) (
  input  logic [1:0][FXD_BITS-1:0]  coord,
  output logic [1:0][FRAC_BITS-1:0] pre_frac,
  output logic [1:0]                pre_par,
  output logic [1:0]                pre_neg,
  output logic [1:0]                pre_ovr,
  input  logic [1:0][FRAC_BITS-1:0] frac,
  input  logic [1:0]                par,
  input  logic [1:0]                neg,
  input  logic [1:0]                ovr,
  input  logic [1:0][1:0]           mode,
  input  logic                      active,
  output logic [1:0][FRAC_BITS-1:0] wrapped,
  output logic                      border
);
  localparam logic [1:0] WRAP_CLAMP  = 2'd0;
  localparam logic [1:0] WRAP_REPEAT = 2'd1;
  localparam logic [1:0] WRAP_MIRROR = 2'd2;
  localparam logic [1:0] WRAP_BORDER = 2'd3;

  logic [1:0] oob;

  // Split each coordinate into its fraction, period-parity bit and the
  // below-zero / at-or-above-one flags.
  always_comb begin
    for (int d = 0; d < 2; d++) begin
      pre_frac[d] = coord[d][FRAC_BITS-1:0];
      pre_par[d]  = coord[d][FRAC_BITS];
      pre_neg[d]  = coord[d][FXD_BITS-1];
      pre_ovr[d]  = !coord[d][FXD_BITS-1] && (|coord[d][FXD_BITS-1:FRAC_BITS]);
    end
  end

  // Apply the per-dimension wrap mode; inactive lanes output zero.
  always_comb begin
    wrapped = '0;
    oob     = '0;
    if (active) begin
      for (int d = 0; d < 2; d++) begin
        case (mode[d])
          WRAP_CLAMP: begin
            if (neg[d])      wrapped[d] = '0;
            else if (ovr[d]) wrapped[d] = '1;
            else             wrapped[d] = frac[d];
          end
          WRAP_REPEAT: wrapped[d] = frac[d];
          WRAP_MIRROR: wrapped[d] = frac[d] ^ {FRAC_BITS{par[d]}};
          WRAP_BORDER: begin
            if (neg[d] || ovr[d]) oob[d] = 1'b1;
            else                  wrapped[d] = frac[d];
          end
          default: wrapped[d] = '0;
        endcase
      end
    end
    border = |oob;
  end
endmodule

module tex_wrap_pipe #(
  parameter int NUM_LANES = 4,
  parameter int FXD_BITS  = 32,
  parameter int FRAC_BITS = 20,
  parameter int TAG_WIDTH = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic [1:0]                         req_wrap_u,
  input  logic [1:0]                         req_wrap_v,
  input  logic [NUM_LANES-1:0]               req_mask,
  input  logic [NUM_LANES*2*FXD_BITS-1:0]    req_coords,
  input  logic [TAG_WIDTH-1:0]               req_tag,
  output logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic [NUM_LANES*2*FRAC_BITS-1:0]   rsp_coords,
  output logic [NUM_LANES-1:0]               rsp_border,
  output logic [NUM_LANES-1:0]               rsp_mask,
  output logic [TAG_WIDTH-1:0]               rsp_tag,
  output logic [31:0]                        border_count
);
  localparam int STAGES = 2;

  typedef struct packed {
    logic [NUM_LANES-1:0][1:0][FRAC_BITS-1:0] frac;
    logic [NUM_LANES-1:0][1:0]                par;
    logic [NUM_LANES-1:0][1:0]                neg;
    logic [NUM_LANES-1:0][1:0]                ovr;
    logic [1:0][1:0]                          mode;
    logic [NUM_LANES-1:0]                     mask;
    logic [TAG_WIDTH-1:0]                     tag;
  } s1_t;

  typedef struct packed {
    logic [NUM_LANES-1:0][1:0][FRAC_BITS-1:0] coords;
    logic [NUM_LANES-1:0]                     border;
    logic [NUM_LANES-1:0]                     mask;
    logic [TAG_WIDTH-1:0]                     tag;
  } rsp_t;

  logic [STAGES:1] vld_pipe;
  logic            s1_adv, s2_adv;
  s1_t             s1_d, s1_q;
  rsp_t            s2_d, s2_q;
  logic [31:0]     bdr_inc;

  logic [NUM_LANES-1:0][1:0][FXD_BITS-1:0]  coords_in;
  logic [NUM_LANES-1:0][1:0][FRAC_BITS-1:0] pre_frac;
  logic [NUM_LANES-1:0][1:0]                pre_par, pre_neg, pre_ovr;
  logic [NUM_LANES-1:0][1:0][FRAC_BITS-1:0] wrapped;
  logic [NUM_LANES-1:0]                     lane_border;

  assign coords_in = req_coords;

  // A stage may load when it is empty or its occupant leaves this cycle.
  assign s2_adv    = !vld_pipe[2] || rsp_ready;
  assign s1_adv    = !vld_pipe[1] || s2_adv;
  assign req_ready = s1_adv;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    tex_wrap_lane #(
      .FXD_BITS  (FXD_BITS),
      .FRAC_BITS (FRAC_BITS)
    ) u_lane (
      .coord    (coords_in[gi]),
      .pre_frac (pre_frac[gi]),
      .pre_par  (pre_par[gi]),
      .pre_neg  (pre_neg[gi]),
      .pre_ovr  (pre_ovr[gi]),
      .frac     (s1_q.frac[gi]),
      .par      (s1_q.par[gi]),
      .neg      (s1_q.neg[gi]),
      .ovr      (s1_q.ovr[gi]),
      .mode     (s1_q.mode),
      .active   (s1_q.mask[gi]),
      .wrapped  (wrapped[gi]),
      .border   (lane_border[gi])
    );
  end

  // Assemble the S1 payload from the request and the lane decode.
  always_comb begin
    s1_d      = '0;
    s1_d.frac = pre_frac;
    s1_d.par  = pre_par;
    s1_d.neg  = pre_neg;
    s1_d.ovr  = pre_ovr;
    s1_d.mode = {req_wrap_v, req_wrap_u};
    s1_d.mask = req_mask;
    s1_d.tag  = req_tag;
  end

  // Assemble the S2 payload from the wrapped lanes.
  always_comb begin
    s2_d        = '0;
    s2_d.coords = wrapped;
    s2_d.border = lane_border;
    s2_d.mask   = s1_q.mask;
    s2_d.tag    = s1_q.tag;
  end

  // Number of border lanes in the response currently presented.
  always_comb begin
    bdr_inc = '0;
    for (int i = 0; i < NUM_LANES; i++) bdr_inc = bdr_inc + 32'(s2_q.border[i]);
  end

  // Pipeline registers; data only moves on a real load so held outputs stay put.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
    end else begin
      if (s1_adv)              vld_pipe[1] <= req_valid;
      if (s1_adv && req_valid) s1_q        <= s1_d;
      if (s2_adv)              vld_pipe[2] <= vld_pipe[1];
      if (s2_adv && vld_pipe[1]) s2_q      <= s2_d;
    end
  end

  // Count border lanes as responses are handed off; wraps naturally.
  always_ff @(posedge clk) begin
    if (reset)                        border_count <= '0;
    else if (vld_pipe[2] && rsp_ready) border_count <= border_count + bdr_inc;
  end

  assign rsp_valid  = vld_pipe[2];
  assign rsp_coords = s2_q.coords;
  assign rsp_border = s2_q.border;
  assign rsp_mask   = s2_q.mask;
  assign rsp_tag    = s2_q.tag;
endmodule

// File: tb/tb_tex_wrap_pipe.sv
// Bench for tex_wrap_pipe: directed mode cases plus randomized traffic
// against an arithmetic reference model of the wrap modes.
module tb_tex_wrap_pipe;
  localparam int NL = 4;
  localparam int FX = 32;
  localparam int FR = 20;
  localparam int TW = 8;

  typedef struct {
    logic [NL*2*FR-1:0] coords;
    logic [NL-1:0]      border;
    logic [NL-1:0]      mask;
    logic [TW-1:0]      tag;
    int                 cyc;
  } rsp_t;

  logic                clk = 1'b0;
  logic                reset;
  logic                req_valid, req_ready;
  logic [1:0]          req_wrap_u, req_wrap_v;
  logic [NL-1:0]       req_mask;
  logic [NL*2*FX-1:0]  req_coords;
  logic [TW-1:0]       req_tag;
  logic                rsp_valid, rsp_ready;
  logic [NL*2*FR-1:0]  rsp_coords;
  logic [NL-1:0]       rsp_border, rsp_mask;
  logic [TW-1:0]       rsp_tag;
  logic [31:0]         border_count;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [31:0] exp_bcount = 0;
  rsp_t        exp_q[$];
  rsp_t        got_q[$];

  tex_wrap_pipe #(.NUM_LANES(NL), .FXD_BITS(FX), .FRAC_BITS(FR), .TAG_WIDTH(TW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wrap_u(req_wrap_u), .req_wrap_v(req_wrap_v),
    .req_mask(req_mask), .req_coords(req_coords), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_coords(rsp_coords), .rsp_border(rsp_border),
    .rsp_mask(rsp_mask), .rsp_tag(rsp_tag),
    .border_count(border_count)
  );

  always #5 clk = ~clk;

  // Reference: treat the coordinate as a real number in units of 2^-FR.
  function automatic logic [FR-1:0] wrap1(input logic [FX-1:0] c, input logic [1:0] m,
                                          output bit oob);
    longint v, one, r;
    v   = longint'(signed'(c));
    one = longint'(1) << FR;
    oob = 0;
    r   = 0;
    case (m)
      2'd0: r = (v < 0) ? 0 : ((v >= one) ? one - 1 : v);
      2'd1: begin r = v % one; if (r < 0) r += one; end
      2'd2: begin
        r = v % (2 * one);
        if (r < 0) r += 2 * one;
        if (r >= one) r = 2 * one - 1 - r;
      end
      default: begin
        if (v >= 0 && v < one) r = v;
        else begin r = 0; oob = 1; end
      end
    endcase
    return FR'(r);
  endfunction

  function automatic rsp_t model(input logic [NL*2*FX-1:0] c, input logic [1:0] wu,
                                 input logic [1:0] wv, input logic [NL-1:0] m,
                                 input logic [TW-1:0] t);
    rsp_t o;
    bit   ob;
    logic [FR-1:0] r;
    o.coords = '0; o.border = '0; o.mask = m; o.tag = t; o.cyc = 0;
    for (int l = 0; l < NL; l++)
      for (int d = 0; d < 2; d++) begin
        r = wrap1(c[(l*2+d)*FX +: FX], (d == 0) ? wu : wv, ob);
        if (m[l]) begin
          o.coords[(l*2+d)*FR +: FR] = r;
          if (ob) o.border[l] = 1'b1;
        end
      end
    return o;
  endfunction

  // Record handshakes seen at the falling edge (inputs settled).
  task automatic sample();
    rsp_t e, g;
    if (req_valid && req_ready) begin
      e = model(req_coords, req_wrap_u, req_wrap_v, req_mask, req_tag);
      e.cyc = cyc;
      exp_q.push_back(e);
    end
    if (rsp_valid && rsp_ready) begin
      g.coords = rsp_coords; g.border = rsp_border; g.mask = rsp_mask;
      g.tag = rsp_tag; g.cyc = cyc;
      got_q.push_back(g);
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FX-1:0] rand_coord();
    logic [FX-1:0] c;
    int sel;
    sel = $urandom_range(0, 3);
    case (sel)
      0: c = $urandom;
      1, 2: c = FX'($urandom_range(0, 6 << FR)) - FX'(3 << FR);
      default: begin
        case ($urandom_range(0, 3))
          0: c = '0;
          1: c = FX'(1 << FR);
          2: c = FX'((1 << FR) - 1);
          default: c = '1;
        endcase
      end
    endcase
    return c;
  endfunction

  task automatic rand_req(input logic [TW-1:0] t);
    for (int i = 0; i < NL * 2; i++) req_coords[i*FX +: FX] = rand_coord();
    req_wrap_u = 2'($urandom_range(0, 3));
    req_wrap_v = 2'($urandom_range(0, 3));
    req_mask   = NL'($urandom);
    req_tag    = t;
  endtask

  task automatic test_reset();
    reset = 1; req_valid = 0; rsp_ready = 0;
    req_wrap_u = 0; req_wrap_v = 0; req_mask = 0; req_coords = '0; req_tag = 0;
    repeat (3) tick();
    vectors++;
    if (rsp_valid !== 0 || rsp_coords !== '0 || rsp_border !== '0 || rsp_mask !== '0 ||
        rsp_tag !== '0 || border_count !== 0 || req_ready !== 1) begin
      miscompares++;
      $display("FAIL reset_state: vld=%b coords=%h border=%b mask=%b tag=%h bc=%0d rdy=%b, want all zero and rdy=1",
               rsp_valid, rsp_coords, rsp_border, rsp_mask, rsp_tag, border_count, req_ready);
    end
    reset = 0;
    tick();
  endtask

  task automatic test_modes();
    logic [31:0] tu[11] = '{32'h00180000, 32'h00180000, 32'h00180000, 32'h00180000,
                            32'hFFFC0000, 32'hFFFC0000, 32'hFFFC0000, 32'hFFFC0000,
                            32'h00040000, 32'h00180000, 32'h00180000};
    logic [31:0] tv[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h00240000, 32'h00180000};
    logic [1:0]  mu[11] = '{1, 2, 0, 3, 1, 2, 0, 3, 3, 3, 3};
    logic [1:0]  mv[11] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 3};
    logic [3:0]  mk[11] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h5};
    logic [19:0] eu[11] = '{20'h80000, 20'h7FFFF, 20'hFFFFF, 0, 20'hC0000, 20'h3FFFF, 0, 0,
                            20'h40000, 0, 0};
    logic [19:0] ev[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 20'h40000, 0};
    logic [3:0]  eb[11] = '{0, 0, 0, 4'hF, 0, 0, 0, 4'hF, 0, 4'hF, 4'h5};
    rsp_t e, g;
    logic [31:0] bc0;
    rsp_ready = 1;
    for (int k = 0; k < 11; k++) begin
      bc0 = border_count;
      for (int l = 0; l < NL; l++) begin
        req_coords[l*2*FX +: FX]      = tu[k];
        req_coords[(l*2+1)*FX +: FX]  = tv[k];
      end
      req_wrap_u = mu[k]; req_wrap_v = mv[k]; req_mask = mk[k]; req_tag = TW'(k);
      req_valid = 1;
      tick();
      req_valid = 0;
      repeat (3) tick();
      vectors++;
      if (exp_q.size() != 1 || got_q.size() != 1) begin
        miscompares++;
        $display("FAIL mode_case%0d_count: accepted=%0d responses=%0d, want 1 and 1",
                 k, exp_q.size(), got_q.size());
        exp_q.delete(); got_q.delete();
        continue;
      end
      e = exp_q.pop_front();
      g = got_q.pop_front();
      vectors++;
      if (g.coords[FR-1:0] !== eu[k] || g.coords[2*FR-1:FR] !== ev[k] || g.border !== eb[k]) begin
        miscompares++;
        $display("FAIL mode_case%0d_const: u=%h v=%h border=%b, want u=%h v=%h border=%b",
                 k, g.coords[FR-1:0], g.coords[2*FR-1:FR], g.border, eu[k], ev[k], eb[k]);
      end
      vectors++;
      if (g.coords !== e.coords || g.border !== e.border || g.mask !== e.mask || g.tag !== e.tag) begin
        miscompares++;
        $display("FAIL mode_case%0d_model: coords=%h border=%b mask=%b tag=%h, want coords=%h border=%b mask=%b tag=%h",
                 k, g.coords, g.border, g.mask, g.tag, e.coords, e.border, e.mask, e.tag);
      end
      vectors++;
      if (g.cyc - e.cyc != 2) begin
        miscompares++;
        $display("FAIL mode_case%0d_latency: %0d cycles, want 2", k, g.cyc - e.cyc);
      end
      exp_bcount += $countones(e.border);
      if (k == 10) begin
        vectors++;
        if (g.coords[2*FR +: 2*FR] !== '0 || g.coords[6*FR +: 2*FR] !== '0 || border_count - bc0 !== 2) begin
          miscompares++;
          $display("FAIL mask_lanes: lane1=%h lane3=%h bc_delta=%0d, want 0 0 2",
                   g.coords[2*FR +: 2*FR], g.coords[6*FR +: 2*FR], border_count - bc0);
        end
      end
    end
    vectors++;
    if (border_count !== exp_bcount) begin
      miscompares++;
      $display("FAIL modes_border_count: %0d, want %0d", border_count, exp_bcount);
    end
  endtask

  // Phase 0: tags 0..5 with rsp_ready 1,0,0,... ; phase 1: random traffic.
  task automatic test_backpressure();
    rsp_t e, g;
    int   n, sent, k, occ;
    bit   pending, stall_prev, done, want_rdy;
    logic [NL*2*FR-1:0] p_coords;
    logic [NL-1:0]      p_border, p_mask;
    logic [TW-1:0]      p_tag;
    for (int ph = 0; ph < 2; ph++) begin
      n = (ph == 0) ? 6 : 150;
      sent = 0; k = 0; pending = 0; stall_prev = 0; done = 0;
      p_coords = '0; p_border = '0; p_mask = '0; p_tag = '0;
      while (!done && k < 3000) begin
        rsp_ready = (ph == 0) ? (k % 3 == 0) : 1'($urandom_range(0, 1));
        if (!pending && sent < n && (ph == 0 || $urandom_range(0, 3) != 0)) begin
          rand_req((ph == 0) ? TW'(sent) : TW'($urandom));
          pending = 1;
        end
        req_valid = pending;
        @(negedge clk);
        occ = exp_q.size() - got_q.size();
        want_rdy = (occ < 2) || rsp_ready;
        vectors++;
        if (req_ready !== want_rdy) begin
          miscompares++;
          $display("FAIL bp_ready: cyc=%0d occ=%0d rsp_ready=%b req_ready=%b, want %b",
                   cyc, occ, rsp_ready, req_ready, want_rdy);
        end
        if (stall_prev) begin
          vectors++;
          if (rsp_valid !== 1 || rsp_coords !== p_coords || rsp_border !== p_border ||
              rsp_mask !== p_mask || rsp_tag !== p_tag) begin
            miscompares++;
            $display("FAIL bp_stable: cyc=%0d vld=%b tag=%h coords=%h, want vld=1 tag=%h coords=%h",
                     cyc, rsp_valid, rsp_tag, rsp_coords, p_tag, p_coords);
          end
        end
        stall_prev = rsp_valid && !rsp_ready;
        p_coords = rsp_coords; p_border = rsp_border; p_mask = rsp_mask; p_tag = rsp_tag;
        if (req_valid && req_ready) begin sent++; pending = 0; end
        sample();
        @(posedge clk);
        #1;
        k++;
        done = (sent == n) && (got_q.size() == exp_q.size());
      end
      req_valid = 0;
      vectors++;
      if (!done) begin
        miscompares++;
        $display("FAIL bp_timeout: phase %0d sent=%0d responses=%0d of %0d", ph, sent, got_q.size(), exp_q.size());
      end
      vectors++;
      if (exp_q.size() != n || got_q.size() != n) begin
        miscompares++;
        $display("FAIL bp_count: phase %0d accepted=%0d responses=%0d, want %0d", ph, exp_q.size(), got_q.size(), n);
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
        e = exp_q.pop_front();
        g = got_q.pop_front();
        vectors++;
        if (g.coords !== e.coords || g.border !== e.border || g.mask !== e.mask || g.tag !== e.tag) begin
          miscompares++;
          $display("FAIL bp_rsp: tag=%h coords=%h border=%b mask=%b, want tag=%h coords=%h border=%b mask=%b",
                   g.tag, g.coords, g.border, g.mask, e.tag, e.coords, e.border, e.mask);
        end
        exp_bcount += $countones(e.border);
      end
      exp_q.delete(); got_q.delete();
      vectors++;
      if (border_count !== exp_bcount) begin
        miscompares++;
        $display("FAIL bp_border_count: phase %0d got %0d, want %0d", ph, border_count, exp_bcount);
      end
    end
  endtask

  task automatic test_throughput();
    rsp_t e, g;
    rsp_ready = 1;
    for (int i = 0; i < 16; i++) begin
      rand_req(TW'(8'h40 + i));
      req_valid = 1;
      @(negedge clk);
      vectors++;
      if (req_ready !== 1) begin
        miscompares++;
        $display("FAIL tput_ready: beat %0d req_ready=%b, want 1", i, req_ready);
      end
      sample();
      @(posedge clk);
      #1;
    end
    req_valid = 0;
    repeat (3) tick();
    vectors++;
    if (exp_q.size() != 16 || got_q.size() != 16) begin
      miscompares++;
      $display("FAIL tput_count: accepted=%0d responses=%0d, want 16", exp_q.size(), got_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      vectors++;
      if (g.coords !== e.coords || g.border !== e.border || g.tag !== e.tag || g.cyc != e.cyc + 2) begin
        miscompares++;
        $display("FAIL tput_rsp: tag=%h cyc=%0d border=%b, want tag=%h cyc=%0d border=%b",
                 g.tag, g.cyc, g.border, e.tag, e.cyc + 2, e.border);
      end
      exp_bcount += $countones(e.border);
    end
    exp_q.delete(); got_q.delete();
    vectors++;
    if (border_count !== exp_bcount) begin
      miscompares++;
      $display("FAIL tput_border_count: %0d, want %0d", border_count, exp_bcount);
    end
  endtask

  task automatic test_reset_midflight();
    rsp_ready = 0;
    for (int i = 0; i < 3; i++) begin
      rand_req(TW'(8'hA0 + i));
      req_mask = '1;
      req_valid = 1;
      tick();
    end
    vectors++;
    if (req_ready !== 0) begin
      miscompares++;
      $display("FAIL mid_full: req_ready=%b with two held requests, want 0", req_ready);
    end
    req_valid = 0;
    reset = 1;
    tick();
    vectors++;
    if (rsp_valid !== 0 || rsp_coords !== '0 || rsp_border !== '0 || rsp_mask !== '0 ||
        rsp_tag !== '0 || border_count !== 0 || req_ready !== 1) begin
      miscompares++;
      $display("FAIL mid_reset: vld=%b coords=%h border=%b mask=%b tag=%h bc=%0d rdy=%b, want zeros and rdy=1",
               rsp_valid, rsp_coords, rsp_border, rsp_mask, rsp_tag, border_count, req_ready);
    end
    reset = 0;
    exp_q.delete(); got_q.delete();
    exp_bcount = 0;
    rsp_ready = 1;
    repeat (4) tick();
    vectors++;
    if (got_q.size() != 0 || border_count !== 0) begin
      miscompares++;
      $display("FAIL mid_discard: %0d responses bc=%0d after reset, want 0 and 0", got_q.size(), border_count);
    end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_backpressure();
    test_throughput();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
